// File: rtl/sumador_pkg.sv
// Shared types and helpers for the registered sumador adder/accumulator.
// Clamp limits are returned as 64-bit values; callers truncate them to their own width.
package sumador_pkg;

  typedef enum logic [1:0] {
    MODE_ADD  = 2'd0,
    MODE_ADDS = 2'd1,
    MODE_SUB  = 2'd2,
    MODE_ACC  = 2'd3
  } mode_e;

  typedef struct packed {
    logic [63:0] hi;
    logic [63:0] lo;
  } sat_lim_t;

  // Signed min is 1 << (width-1), which reads as 100..0 once truncated to width bits.
  function automatic sat_lim_t sat_limits(input int unsigned width, input bit is_signed);
    sat_lim_t lim;
    if (is_signed) begin
      lim.hi = (64'd1 << (width - 1)) - 64'd1;
      lim.lo = 64'd1 << (width - 1);
    end else begin
      lim.hi = (64'd1 << width) - 64'd1;
      lim.lo = '0;
    end
    return lim;
  endfunction

endpackage

// File: rtl/sumador_if.sv
// Operand/result handshake bundle for sumador_pipe.
// The master drives operands and takes results; the slave is the adder block.
interface sumador_if #(
  parameter int unsigned WIDTH = 16
);
  import sumador_pkg::*;

  logic             in_valid;
  logic             in_ready;
  mode_e            mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] c;
  logic             carry;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, mode, a, b, acc_clr, out_ready,
    input  in_ready, out_valid, c, carry, overflow, zero
  );

  modport slave (
    input  in_valid, mode, a, b, acc_clr, out_ready,
    output in_ready, out_valid, c, carry, overflow, zero
  );

endinterface

// File: rtl/sumador_core.sv
// Combinational WIDTH-bit add/subtract with carry, overflow and optional clamping.
// Subtraction is x + ~y + 1 so a single WIDTH+1-bit sum serves both operations.
module sumador_core
  import sumador_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  input  logic             sat,
  input  logic             signed_mode,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);

  localparam sat_lim_t LimU = sat_limits(WIDTH, 1'b0);
  localparam sat_lim_t LimS = sat_limits(WIDTH, 1'b1);
  localparam logic [WIDTH-1:0] UMax = LimU.hi[WIDTH-1:0];
  localparam logic [WIDTH-1:0] UMin = LimU.lo[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SMax = LimS.hi[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SMin = LimS.lo[WIDTH-1:0];

  logic [WIDTH-1:0] y_eff;
  logic [WIDTH-1:0] raw;
  logic [WIDTH:0]   ext;
  logic             ovf_u;
  logic             ovf_s;

  assign y_eff = sub ? ~y : y;
  assign ext   = {1'b0, x} + {1'b0, y_eff} + {{WIDTH{1'b0}}, sub};
  assign raw   = ext[WIDTH-1:0];
  assign carry = ext[WIDTH];

  // Carry out of a subtract is borrow-not, so unsigned underflow is its inverse.
  assign ovf_u = sub ? ~carry : carry;
  assign ovf_s = (x[WIDTH-1] == y_eff[WIDTH-1]) && (raw[WIDTH-1] != x[WIDTH-1]);
  assign ovf   = signed_mode ? ovf_s : ovf_u;

  always_comb begin
    sum = raw;
    if (sat && ovf) begin
      if (signed_mode) begin
        sum = x[WIDTH-1] ? SMin : SMax;
      end else begin
        sum = sub ? UMin : UMax;
      end
    end
  end

endmodule

// File: rtl/sumador_pipe.sv
// Registered adder/subtractor/accumulator with valid/ready on both sides, 1-cycle latency.
// in_ready is combinational on out_ready so the block sustains one beat per cycle.
module sumador_pipe
  import sumador_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter bit          SIGNED = 1'b0
) (
  input logic      clk,
  input logic      rst_n,
  sumador_if.slave bus
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic             in_ready;
  logic             accept;
  logic             is_acc;
  logic [WIDTH-1:0] core_x;
  logic [WIDTH-1:0] core_y;
  logic [WIDTH-1:0] core_sum;
  logic             core_carry;
  logic             core_ovf;

  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;
  assign is_acc   = (bus.mode == MODE_ACC);

  // A clear arriving with an ACC beat zeroes the running sum before adding a.
  always_comb begin
    core_x = bus.a;
    core_y = bus.b;
    if (is_acc) begin
      core_x = bus.acc_clr ? '0 : acc_q;
      core_y = bus.a;
    end
  end

  sumador_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .x          (core_x),
    .y          (core_y),
    .sub        (bus.mode == MODE_SUB),
    .sat        (bus.mode == MODE_ADDS),
    .signed_mode(SIGNED),
    .sum        (core_sum),
    .carry      (core_carry),
    .ovf        (core_ovf)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    c_d         = c_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    acc_d       = acc_q;
    if (accept) begin
      out_valid_d = 1'b1;
      c_d         = core_sum;
      carry_d     = core_carry;
      ovf_d       = core_ovf;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    if (accept && is_acc) begin
      acc_d = core_sum;
    end else if (bus.acc_clr) begin
      acc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      c_q         <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      acc_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      c_q         <= c_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      acc_q       <= acc_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.c         = c_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = (c_q == '0);

endmodule
